// File: rtl/req_initiator_if.sv
// ----------------------------------------------------------------------------
// req_initiator_if
//
// Groups the host control signals and the processor req/ack run handshake
// seen by req_initiator.
//
//   start        host -> initiator  single-cycle batch start request
//   num_runs     host -> initiator  runs in the batch, sampled on start
//   ack          core -> initiator  run-complete indication
//   req          initiator -> core  run request
//   busy         initiator -> host  batch in progress
//   done         initiator -> host  sticky, batch completed cleanly
//   timeout_err  initiator -> host  sticky, core failed to ack in time
//   run_idx      initiator -> host  current run / completed run count
//   last_cycles  initiator -> host  WAIT-cycle count of the last acked run
//
// Modports:
//   master  the initiator (drives req and the status outputs)
//   slave   the host/core side (drives start, num_runs, ack)
// ----------------------------------------------------------------------------
interface req_initiator_if #(
    parameter int unsigned CW = 16
);
    logic          start;
    logic [3:0]    num_runs;
    logic          ack;
    logic          req;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [3:0]    run_idx;
    logic [CW-1:0] last_cycles;

    modport master (
        input  start,
        input  num_runs,
        input  ack,
        output req,
        output busy,
        output done,
        output timeout_err,
        output run_idx,
        output last_cycles
    );

    modport slave (
        output start,
        output num_runs,
        output ack,
        input  req,
        input  busy,
        input  done,
        input  timeout_err,
        input  run_idx,
        input  last_cycles
    );
endinterface

// File: rtl/req_initiator.sv
// ----------------------------------------------------------------------------
// req_initiator
//
// Host-side initiator for the processor req/ack run handshake. On start it
// launches num_runs back-to-back runs: req is held for REQ_CYCLES cycles, then
// the block waits for ack, recording how many WAIT cycles the run took. Runs
// are separated by GAP_CYCLES idle cycles. A core that does not ack within
// TIMEOUT WAIT cycles ends the batch with timeout_err.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    req_initiator_if.master (start, num_runs, ack in;
//          req, busy, done, timeout_err, run_idx, last_cycles out)
//
// Every output comes straight from a flop; nothing in the input-to-output
// path is combinational.
// ----------------------------------------------------------------------------
module req_initiator #(
    parameter int unsigned REQ_CYCLES = 2,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned CW         = 16
) (
    input  logic              clk,
    input  logic              reset,
    req_initiator_if.master   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StGap,
        StDone,
        StErr
    } state_e;

    state_e        state_q, state_d;

    // Shared phase counter: cycles spent in REQ, or cycles spent in GAP.
    logic [CW-1:0] cnt_q, cnt_d;
    // WAIT cycles elapsed without ack in the current run.
    logic [CW-1:0] wait_q, wait_d;
    // Run count latched when start is accepted.
    logic [3:0]    runs_q, runs_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] last_q, last_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [CW-1:0] wait_inc;
    logic [3:0]    idx_inc;

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        runs_d   = runs_q;
        idx_d    = idx_q;
        last_d   = last_q;
        done_d   = done_q;
        err_d    = err_q;

        // The first WAIT cycle counts as 1, so the count for this cycle is
        // always one more than the cycles already elapsed.
        wait_inc = wait_q + CW'(1);
        idx_inc  = idx_q + 4'd1;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.start) begin
                    runs_d = bus.num_runs;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    idx_d  = 4'd0;
                    cnt_d  = '0;
                    if (bus.num_runs != 4'd0) begin
                        state_d = StReq;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end

            // ack is ignored here: the core drops it while it sees req.
            StReq: begin
                if (cnt_q == CW'(REQ_CYCLES - 1)) begin
                    state_d = StWait;
                    cnt_d   = '0;
                    wait_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // ack is checked before the timeout so an ack on the limit cycle
            // still completes the run.
            StWait: begin
                if (bus.ack) begin
                    last_d = wait_inc;
                    idx_d  = idx_inc;
                    cnt_d  = '0;
                    if (idx_inc == runs_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = StReq;
                    end else begin
                        state_d = StGap;
                    end
                end else if (wait_inc == CW'(TIMEOUT)) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end

            // ack is ignored during the inter-run gap.
            StGap: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Flag outputs are registered copies of the next-state decode so they
        // line up with state_q on every cycle.
        req_d  = (state_d == StReq);
        busy_d = (state_d == StReq) || (state_d == StWait) || (state_d == StGap);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wait_q  <= '0;
            runs_q  <= 4'd0;
            idx_q   <= 4'd0;
            last_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            runs_q  <= runs_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.req         = req_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;
    assign bus.run_idx     = idx_q;
    assign bus.last_cycles = last_q;

endmodule

// File: tb/tb_req_initiator.sv
// ----------------------------------------------------------------------------
// tb_req_initiator
//
// Drives batches of runs with per-run ack latencies. The expected req pulse
// starts/widths, end cycle and final status of each batch are computed from
// the timing rules with plain arithmetic (model_batch) and compared with what
// the monitor loop in run_batch observes.
// ----------------------------------------------------------------------------
module tb_req_initiator;

    localparam int REQ = 2;
    localparam int GAP = 4;
    localparam int TO  = 20;
    localparam int CW  = 16;

    logic clk;
    logic reset;

    req_initiator_if #(.CW(CW)) bus ();

    req_initiator #(
        .REQ_CYCLES (REQ),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO),
        .CW         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;

    // Per-run ack latency in WAIT cycles; a value above TO means never ack.
    int    lat [16];

    string obs_sig, exp_sig;
    int    obs_end, exp_end;
    bit    exp_done, exp_err;
    int    exp_idx;
    int    model_last = 0;

    function automatic logic [23:0] status();
        return {bus.req, bus.busy, bus.done, bus.timeout_err, bus.run_idx, bus.last_cycles};
    endfunction

    function automatic logic [23:0] exp_status();
        return {1'b0, 1'b0, exp_done, exp_err, 4'(exp_idx), 16'(model_last)};
    endfunction

    // Expected behaviour of one batch. Cycle c is the sample after the c-th
    // edge following the cycle in which start is driven.
    task automatic model_batch(input int n);
        int t;
        exp_sig  = "";
        exp_end  = -1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_idx  = 0;
        if (n == 0) begin
            exp_end  = 1;
            exp_done = 1'b1;
            return;
        end
        t = 1;
        for (int r = 0; r < n; r++) begin
            exp_sig = {exp_sig, $sformatf("%0d/%0d ", t, REQ)};
            if (lat[r] > TO) begin
                exp_end = t + REQ + TO;
                exp_err = 1'b1;
                return;
            end
            t          += REQ + lat[r];
            model_last  = lat[r];
            exp_idx     = r + 1;
            if (r == n - 1) begin
                exp_end  = t;
                exp_done = 1'b1;
            end else begin
                t += GAP;
            end
        end
    endtask

    // Stimulus + monitor: starts a batch, answers each req with ack after
    // lat[run] WAIT cycles, records req pulses and the cycle busy drops.
    task automatic run_batch(input int n, input bit noise, input int intr_cycle,
                             input int intr_num);
        bit waiting, prev_req;
        int wcount, run, rise, width;
        waiting  = 1'b0;
        prev_req = 1'b0;
        wcount   = 0;
        run      = 0;
        rise     = 0;
        width    = 0;
        obs_sig  = "";
        obs_end  = -1;
        bus.num_runs = 4'(n);
        bus.start    = 1'b1;
        bus.ack      = noise;
        for (int c = 1; c <= 800; c++) begin
            @(posedge clk);
            #1;
            bus.start    = 1'b0;
            bus.num_runs = 4'($urandom);
            if (c == intr_cycle) begin
                bus.start    = 1'b1;
                bus.num_runs = 4'(intr_num);
            end
            if (bus.req && !prev_req) begin
                rise  = c;
                width = 0;
            end
            if (bus.req) width++;
            if (!bus.req && prev_req) begin
                obs_sig = {obs_sig, $sformatf("%0d/%0d ", rise, width)};
                waiting = 1'b1;
                wcount  = 0;
            end
            prev_req = bus.req;
            if (!bus.busy) begin
                obs_end = c;
                break;
            end
            if (waiting) begin
                wcount++;
                if (wcount == lat[run]) begin
                    bus.ack = 1'b1;
                    waiting = 1'b0;
                    run++;
                end else begin
                    bus.ack = 1'b0;
                end
            end else begin
                bus.ack = noise;
            end
        end
        bus.start = 1'b0;
        bus.ack   = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.ack      = 1'b0;
        bus.num_runs = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (status() !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", status(), 24'h0);
        end
        reset   = 1'b1;
        bus.ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.ack = 1'b0;
        checks++;
        if (status() !== 24'h0) begin
            errors++;
            $display("FAIL idle_hold: got %h want %h", status(), 24'h0);
        end
        model_last = 0;
    endtask

    task automatic test_timeout();
        lat[0] = TO + 1;
        model_batch(1);
        run_batch(1, 1'b0, 0, 0);
        checks++;
        if (obs_sig != exp_sig) begin
            errors++;
            $display("FAIL timeout pulses: got '%s' want '%s'", obs_sig, exp_sig);
        end
        checks++;
        if (obs_end != exp_end) begin
            errors++;
            $display("FAIL timeout end: got %0d want %0d", obs_end, exp_end);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (status() !== exp_status()) begin
            errors++;
            $display("FAIL timeout status: got %h want %h", status(), exp_status());
        end
        lat[0] = 1;
        model_batch(1);
        run_batch(1, 1'b0, 0, 0);
        checks++;
        if (obs_end != exp_end || status() !== exp_status()) begin
            errors++;
            $display("FAIL timeout_restart: got end %0d st %h want end %0d st %h",
                     obs_end, status(), exp_end, exp_status());
        end
    endtask

    task automatic test_single();
        lat[0] = 10;
        model_batch(1);
        run_batch(1, 1'b0, 0, 0);
        checks++;
        if (obs_sig != exp_sig) begin
            errors++;
            $display("FAIL single pulses: got '%s' want '%s'", obs_sig, exp_sig);
        end
        checks++;
        if (obs_end != exp_end || status() !== exp_status()) begin
            errors++;
            $display("FAIL single end/status: got %0d %h want %0d %h",
                     obs_end, status(), exp_end, exp_status());
        end
    endtask

    task automatic test_batch();
        lat[0] = 5;
        lat[1] = 7;
        lat[2] = 3;
        model_batch(3);
        run_batch(3, 1'b0, 0, 0);
        checks++;
        if (obs_sig != exp_sig) begin
            errors++;
            $display("FAIL batch pulses: got '%s' want '%s'", obs_sig, exp_sig);
        end
        checks++;
        if (obs_end != exp_end) begin
            errors++;
            $display("FAIL batch end: got %0d want %0d", obs_end, exp_end);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (status() !== exp_status()) begin
            errors++;
            $display("FAIL batch sticky status: got %h want %h", status(), exp_status());
        end
    endtask

    task automatic test_zero_runs();
        model_batch(0);
        run_batch(0, 1'b0, 0, 0);
        checks++;
        if (obs_sig != exp_sig || obs_end != exp_end) begin
            errors++;
            $display("FAIL zero_runs: got '%s' end %0d want '%s' end %0d",
                     obs_sig, obs_end, exp_sig, exp_end);
        end
        checks++;
        if (status() !== exp_status()) begin
            errors++;
            $display("FAIL zero_runs status: got %h want %h", status(), exp_status());
        end
    endtask

    task automatic test_ack_noise();
        lat[0] = 2;
        lat[1] = 9;
        lat[2] = 4;
        model_batch(3);
        run_batch(3, 1'b1, 0, 0);
        checks++;
        if (obs_sig != exp_sig || obs_end != exp_end) begin
            errors++;
            $display("FAIL ack_noise: got '%s' end %0d want '%s' end %0d",
                     obs_sig, obs_end, exp_sig, exp_end);
        end
        checks++;
        if (status() !== exp_status()) begin
            errors++;
            $display("FAIL ack_noise status: got %h want %h", status(), exp_status());
        end
    endtask

    task automatic test_timeout_edge();
        lat[0] = TO;
        lat[1] = TO;
        model_batch(2);
        run_batch(2, 1'b0, 0, 0);
        checks++;
        if (obs_sig != exp_sig || obs_end != exp_end) begin
            errors++;
            $display("FAIL timeout_edge: got '%s' end %0d want '%s' end %0d",
                     obs_sig, obs_end, exp_sig, exp_end);
        end
        checks++;
        if (status() !== exp_status()) begin
            errors++;
            $display("FAIL timeout_edge status: got %h want %h", status(), exp_status());
        end
    endtask

    task automatic test_reset_mid_wait();
        // Run 0 acks on WAIT cycle 3 (rise 1, ack at sample 5); run 1 rises at
        // 10 and is in its second WAIT cycle at sample 13.
        bus.num_runs = 4'd3;
        bus.start    = 1'b1;
        bus.ack      = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.ack   = (c == 5);
        end
        checks++;
        if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'd3}) begin
            errors++;
            $display("FAIL mid_wait pre-reset: got %h want %h", status(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'd3});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        model_last = 0;
        checks++;
        if (status() !== 24'h0) begin
            errors++;
            $display("FAIL mid_wait reset: got %h want %h", status(), 24'h0);
        end
        lat[0] = 4;
        lat[1] = 6;
        model_batch(2);
        run_batch(2, 1'b0, 0, 0);
        checks++;
        if (obs_sig != exp_sig || obs_end != exp_end || status() !== exp_status()) begin
            errors++;
            $display("FAIL mid_wait restart: got '%s' %0d %h want '%s' %0d %h",
                     obs_sig, obs_end, status(), exp_sig, exp_end, exp_status());
        end
    endtask

    task automatic test_start_while_busy();
        lat[0] = 6;
        lat[1] = 6;
        model_batch(2);
        run_batch(2, 1'b0, 5, 5);
        checks++;
        if (obs_sig != exp_sig || obs_end != exp_end) begin
            errors++;
            $display("FAIL start_busy: got '%s' end %0d want '%s' end %0d",
                     obs_sig, obs_end, exp_sig, exp_end);
        end
        checks++;
        if (status() !== exp_status()) begin
            errors++;
            $display("FAIL start_busy status: got %h want %h", status(), exp_status());
        end
    endtask

    task automatic test_random();
        int n;
        bit noise;
        for (int k = 0; k < 8; k++) begin
            n     = int'($urandom_range(0, 15));
            noise = 1'($urandom);
            for (int r = 0; r < 16; r++) begin
                lat[r] = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(1, TO));
            end
            model_batch(n);
            run_batch(n, noise, 0, 0);
            checks++;
            if (obs_sig != exp_sig || obs_end != exp_end) begin
                errors++;
                $display("FAIL random[%0d] n=%0d: got '%s' end %0d want '%s' end %0d",
                         k, n, obs_sig, obs_end, exp_sig, exp_end);
            end
            checks++;
            if (status() !== exp_status()) begin
                errors++;
                $display("FAIL random[%0d] status: got %h want %h", k, status(), exp_status());
            end
        end
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.ack      = 1'b0;
        bus.num_runs = 4'd0;
        test_reset();
        test_timeout();
        test_single();
        test_batch();
        test_zero_runs();
        test_ack_noise();
        test_timeout_edge();
        test_reset_mid_wait();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/req_initiator.md
Name: req_initiator

Overview:
- Host-side initiator for the processor's req/ack run handshake.
- Launches a programmed number of back-to-back program runs: it pulses req, then waits for ack.
- Measures the execution latency of each run and flags a hung core with a timeout.
- Sits between the test/host control logic and the processor top level. It drives the core's req input and observes its ack output.

Parameters:
- REQ_CYCLES, 2: number of cycles req is held high per run (minimum 1).
- GAP_CYCLES, 4: idle cycles between an accepted ack and the next req (0 allowed).
- TIMEOUT, 4096: maximum WAIT cycles before declaring the core hung.
- CW, 16: width of the cycle counter and last_cycles. Must be large enough to hold TIMEOUT.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: single-cycle request to begin a batch of runs.
- num_runs, input, 4: number of runs in the batch; sampled only when start is accepted.
- ack, input, 1: processor run-complete indication.
- req, output, 1: run request to the processor.
- busy, output, 1: high while a batch is in progress (states REQ, WAIT, GAP).
- done, output, 1: sticky; batch completed without error.
- timeout_err, output, 1: sticky; the core failed to ack within TIMEOUT.
- run_idx, output, 4: index of the current run, or the number of completed runs once finished.
- last_cycles, output, CW: WAIT-cycle count of the most recently acked run.

Behaviour:
- Reset: sampled at the clk edge while reset==0.
  - State goes to IDLE.
  - req, busy, done, timeout_err are 0; run_idx is 0; last_cycles is 0; internal counters are 0.
  - Reset takes priority over every other event. A reset mid-batch drops req on the next edge and discards the batch.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, REQ, WAIT, GAP, DONE, ERR.
- IDLE, DONE, ERR with start==1:
  - num_runs is latched; done, timeout_err and run_idx are cleared.
  - If num_runs!=0: go to REQ, with req=1 from the next cycle.
  - If num_runs==0: go straight to DONE with done=1. req never rises.
  - Without start, these states hold and keep their sticky flags.
- start while busy==1 is ignored. num_runs changes during a batch have no effect.
- REQ:
  - req=1 for exactly REQ_CYCLES consecutive cycles.
  - ack is ignored in this state, because the core clears ack while it sees req.
  - Then go to WAIT, with req=0 and the wait counter reset to 0.
- WAIT:
  - On each cycle, if ack==1: last_cycles = wait_count+1, where the first WAIT cycle counts as 1.
    - run_idx increments.
    - If the new run_idx equals num_runs, go to DONE (done=1, busy=0).
    - Otherwise go to GAP, or directly to REQ when GAP_CYCLES==0.
  - If ack==0: wait_count increments.
    - If wait_count+1 reaches TIMEOUT, go to ERR: timeout_err=1, busy=0, req=0. last_cycles is unchanged.
  - ack==1 on the same cycle the timeout limit is reached: ack wins and the run counts as complete.
- GAP:
  - Count GAP_CYCLES cycles with ack ignored, then go to REQ.
- run_idx width: a maximum of 15 runs per batch. No wrap, since num_runs is limited to 15.
- ERR and DONE are terminal until start or reset.

Test Plan:
- Single run: REQ_CYCLES=2; start with num_runs=1; drive ack high 10 cycles after req falls.
  - req high exactly 2 cycles; last_cycles=10; done=1; run_idx=1; busy=0.
- Batch: num_runs=3, GAP_CYCLES=4, ack latencies 5, 7, 3.
  - Three req pulses, each separated by exactly 4 idle cycles after the ack cycle.
  - last_cycles ends at 3; run_idx=3; done=1.
- Timeout: TIMEOUT=20, ack never asserted.
  - ERR after 20 WAIT cycles; timeout_err=1; req=0; last_cycles=0.
  - A following start with num_runs=1 and prompt ack clears timeout_err and sets done=1.
- Edge cases:
  - num_runs=0 → done=1 one cycle after start, and req is never asserted.
  - ack held high throughout REQ and GAP → ignored; only WAIT-state ack counts.
  - ack on the exact timeout cycle → run completes and no error is flagged.
- Reset mid-WAIT: reset low for one cycle during run 2 of 3.
  - Next cycle: all outputs 0, state IDLE.
  - start accepted normally afterwards.
- start pulsed while busy with num_runs=5 → ignored; the batch completes with the originally latched count.
